// File: rtl/mod3_word_assembler_pkg.sv
// Shared constants and types for the mod-3 word assembler.
// Holds the word width, the 2-bit remainder type and its legal values.
package mod3_pkg;

  localparam int WORD_W = 8;

  typedef logic [1:0] rem_t;

  localparam rem_t REM0 = 2'd0;
  localparam rem_t REM1 = 2'd1;
  localparam rem_t REM2 = 2'd2;

  // 2r mod 3 simply swaps remainders 1 and 2
  function automatic rem_t remDouble(input rem_t r);
    case (r)
      REM1:    remDouble = REM2;
      REM2:    remDouble = REM1;
      default: remDouble = REM0;
    endcase
  endfunction

endpackage

// File: rtl/mod3_word_assembler_if.sv
// Serial-bit-in / word-out bus of the mod-3 word assembler.
// master = upstream/downstream environment, slave = the assembler itself.
// word_rem only exists when MOD3_TRACK_EN is defined.
interface mod3_word_assembler_if;
  import mod3_pkg::*;

  logic              bit_in;
  logic              bit_valid;
  logic              bit_ready;
  logic              sof;
  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic              word_ready;
  logic [2:0]        bit_count;
`ifdef MOD3_TRACK_EN
  rem_t              word_rem;
`endif

`ifdef MOD3_TRACK_EN
  modport master (output bit_in, bit_valid, sof, word_ready,
                  input  bit_ready, word_out, word_valid, bit_count, word_rem);
  modport slave  (input  bit_in, bit_valid, sof, word_ready,
                  output bit_ready, word_out, word_valid, bit_count, word_rem);
`else
  modport master (output bit_in, bit_valid, sof, word_ready,
                  input  bit_ready, word_out, word_valid, bit_count);
  modport slave  (input  bit_in, bit_valid, sof, word_ready,
                  output bit_ready, word_out, word_valid, bit_count);
`endif

endinterface

// File: rtl/mod3_word_assembler_step.sv
// One step of the running mod-3 remainder: next = (rem + bit*weight) mod 3.
// Callers fold any doubling of the old remainder into rem_i.
module mod3_step
  import mod3_pkg::*;
(
  input  rem_t       rem_i,
  input  logic       bit_i,
  input  logic [1:0] weight_i,
  output rem_t       rem_o
);

  logic [2:0] sum;

  // Sum is at most 2+2=4, so a single conditional subtract reduces it
  always_comb begin
    sum   = {1'b0, rem_i} + (bit_i ? {1'b0, weight_i} : 3'd0);
    rem_o = (sum >= 3'd3) ? rem_t'(sum - 3'd3) : rem_t'(sum);
  end

endmodule

// File: rtl/mod3_word_assembler.sv
// Serial-to-parallel 8-bit word assembler with valid/ready on both sides.
// MSB_FIRST selects whether the first serial bit lands in bit 7 or bit 0.
// Optional feature macro MOD3_TRACK_EN adds a running mod-3 remainder
// presented on word_rem alongside each completed word.
module mod3_word_assembler
  import mod3_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  mod3_word_assembler_if.slave bus
);

  logic [2:0]        bitCount_q, bitCount_d;
  logic [WORD_W-1:0] partial_q, partial_d;
  logic [WORD_W-1:0] wordOut_q, wordOut_d;
  logic              wordValid_q, wordValid_d;
  logic              accept;
  logic              loadWord;
  logic [2:0]        bitIdx;
  logic [2:0]        bitPos;
  logic [WORD_W-1:0] merged;

  // Only the last bit of a word can stall, and only behind an unconsumed word
  assign bus.bit_ready = !rst && !(bitCount_q == 3'd7 && wordValid_q && !bus.word_ready);
  assign accept        = bus.bit_valid && bus.bit_ready;
  assign bitIdx        = bus.sof ? 3'd0 : bitCount_q;
  assign bitPos        = MSB_FIRST ? (3'd7 - bitIdx) : bitIdx;
  assign loadWord      = accept && (bitIdx == 3'd7);

  assign bus.word_out   = wordOut_q;
  assign bus.word_valid = wordValid_q;
  assign bus.bit_count  = bitCount_q;

  // Next partial word, bit count and output register
  always_comb begin
    partial_d   = partial_q;
    bitCount_d  = bitCount_q;
    wordOut_d   = wordOut_q;
    wordValid_d = wordValid_q;
    merged      = bus.sof ? '0 : partial_q;
    merged[bitPos] = bus.bit_in;
    if (wordValid_q && bus.word_ready) begin
      wordValid_d = 1'b0;
    end
    if (loadWord) begin
      wordOut_d   = merged;
      wordValid_d = 1'b1;
      partial_d   = '0;
      bitCount_d  = 3'd0;
    end else if (accept) begin
      partial_d  = merged;
      bitCount_d = bitIdx + 3'd1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      bitCount_q  <= 3'd0;
      partial_q   <= '0;
      wordOut_q   <= '0;
      wordValid_q <= 1'b0;
    end else begin
      bitCount_q  <= bitCount_d;
      partial_q   <= partial_d;
      wordOut_q   <= wordOut_d;
      wordValid_q <= wordValid_d;
    end
  end

`ifdef MOD3_TRACK_EN
  rem_t       rem_q, rem_d;
  rem_t       wordRem_q, wordRem_d;
  rem_t       remBase;
  rem_t       remIn;
  rem_t       remNext;
  logic [1:0] weight;

  // MSB-first doubles the old remainder; LSB-first weights odd positions by 2
  assign remBase = bus.sof ? REM0 : rem_q;
  assign remIn   = MSB_FIRST ? remDouble(remBase) : remBase;
  assign weight  = (MSB_FIRST || !bitIdx[0]) ? 2'd1 : 2'd2;

  mod3_step uStep (
    .rem_i    (remIn),
    .bit_i    (bus.bit_in),
    .weight_i (weight),
    .rem_o    (remNext)
  );

  assign bus.word_rem = wordRem_q;

  // Running remainder restarts at each word boundary; final value follows the word
  always_comb begin
    rem_d     = rem_q;
    wordRem_d = wordRem_q;
    if (loadWord) begin
      rem_d     = REM0;
      wordRem_d = remNext;
    end else if (accept) begin
      rem_d = remNext;
    end
  end

  // Remainder registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q     <= REM0;
      wordRem_q <= REM0;
    end else begin
      rem_q     <= rem_d;
      wordRem_q <= wordRem_d;
    end
  end
`endif

endmodule

// File: tb/tb_mod3_word_assembler.sv
// Testbench for mod3_word_assembler: drives an MSB-first and an LSB-first
// instance with identical stimulus and compares both against a bit-list
// reference model every cycle, plus directed scenarios with fixed expectations.
module tb_mod3_word_assembler;
  import mod3_pkg::*;

  logic clk = 1'b0;
  logic rst;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model state, index 0 = MSB-first instance, 1 = LSB-first
  int modelCnt[2];
  bit modelBits[2][8];
  int pendWord[2];
  bit pendValid[2];
  bit expReady[2];

  mod3_word_assembler_if busM ();
  mod3_word_assembler_if busL ();

  mod3_word_assembler #(.MSB_FIRST(1'b1)) dutM (.clk(clk), .rst(rst), .bus(busM));
  mod3_word_assembler #(.MSB_FIRST(1'b0)) dutL (.clk(clk), .rst(rst), .bus(busL));

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkDut(input int m, input logic rdy, input logic wv,
                          input logic [7:0] wo, input logic [2:0] bc, input logic [1:0] rem);
    string n;
    n = (m == 0) ? "msb" : "lsb";
    checkOutput({n, ".bit_ready"},  32'(rdy), 32'(expReady[m]));
    checkOutput({n, ".word_valid"}, 32'(wv),  32'(pendValid[m]));
    checkOutput({n, ".word_out"},   32'(wo),  32'(pendWord[m]));
    checkOutput({n, ".bit_count"},  32'(bc),  32'(modelCnt[m]));
`ifdef MOD3_TRACK_EN
    checkOutput({n, ".word_rem"},   32'(rem), 32'(pendWord[m] % 3));
`else
    if (rem !== 2'b00) checkOutput({n, ".rem_stub"}, 32'(rem), 32'd0);
`endif
  endtask

  // One clock cycle: drive, check at negedge, advance model, return at posedge+1
  task automatic applyStimulus(input logic b, input logic v, input logic s,
                               input logic wr, input logic r);
    logic [1:0] remM, remL;
    int w;
    bit loaded;
    busM.bit_in = b; busM.bit_valid = v; busM.sof = s; busM.word_ready = wr;
    busL.bit_in = b; busL.bit_valid = v; busL.sof = s; busL.word_ready = wr;
    rst = r;
    for (int m = 0; m < 2; m++)
      expReady[m] = !r && !(modelCnt[m] == 7 && pendValid[m] && !wr);
    @(negedge clk);
`ifdef MOD3_TRACK_EN
    remM = busM.word_rem; remL = busL.word_rem;
`else
    remM = 2'b00; remL = 2'b00;
`endif
    checkDut(0, busM.bit_ready, busM.word_valid, busM.word_out, busM.bit_count, remM);
    checkDut(1, busL.bit_ready, busL.word_valid, busL.word_out, busL.bit_count, remL);
    for (int m = 0; m < 2; m++) begin
      if (r) begin
        modelCnt[m] = 0; pendValid[m] = 0; pendWord[m] = 0;
      end else begin
        loaded = 0;
        w = 0;
        if (v && expReady[m]) begin
          if (s) modelCnt[m] = 0;
          modelBits[m][modelCnt[m]] = b;
          modelCnt[m]++;
          if (modelCnt[m] == 8) begin
            for (int i = 0; i < 8; i++)
              w += int'(modelBits[m][i]) << ((m == 0) ? (7 - i) : i);
            loaded = 1;
            modelCnt[m] = 0;
          end
        end
        if (loaded) begin
          pendWord[m] = w; pendValid[m] = 1;
        end else if (pendValid[m] && wr) begin
          pendValid[m] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Send n bits of pattern, first bit taken from pattern[7]
  task automatic sendBits(input logic [7:0] pattern, input int n, input logic sofFirst, input logic wr);
    for (int i = 0; i < n; i++)
      applyStimulus(pattern[7 - i], 1'b1, sofFirst && (i == 0), wr, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      modelCnt[m] = 0; pendWord[m] = 0; pendValid[m] = 0; expReady[m] = 0;
    end
    rst = 1'b1;
    busM.bit_in = 0; busM.bit_valid = 0; busM.sof = 0; busM.word_ready = 0;
    busL.bit_in = 0; busL.bit_valid = 0; busL.sof = 0; busL.word_ready = 0;
    @(posedge clk); #1;
    doReset();
    checkOutput("reset.bit_ready", 32'(busM.bit_ready), 32'd0);

    // 1,0,0,1,0,1,1,0 with word_ready held high
    sendBits(8'h96, 8, 1'b1, 1'b1);
    checkOutput("w96.valid", 32'(busM.word_valid), 32'd1);
    checkOutput("w96.msb", 32'(busM.word_out), 32'h96);
    checkOutput("w96.lsb", 32'(busL.word_out), 32'h69);
`ifdef MOD3_TRACK_EN
    checkOutput("w96.rem", 32'(busM.word_rem), 32'd0);
`endif

    // Back-to-back 0x07, 0x05, then 0xFF
    sendBits(8'h07, 8, 1'b0, 1'b1);
    checkOutput("w07.msb", 32'(busM.word_out), 32'h07);
`ifdef MOD3_TRACK_EN
    checkOutput("w07.rem", 32'(busM.word_rem), 32'd1);
`endif
    sendBits(8'h05, 8, 1'b0, 1'b1);
    checkOutput("w05.msb", 32'(busM.word_out), 32'h05);
`ifdef MOD3_TRACK_EN
    checkOutput("w05.rem", 32'(busM.word_rem), 32'd2);
`endif
    sendBits(8'hFF, 8, 1'b0, 1'b1);
    checkOutput("wFF.msb", 32'(busM.word_out), 32'hFF);
`ifdef MOD3_TRACK_EN
    checkOutput("wFF.rem", 32'(busM.word_rem), 32'd0);
`endif

    // Backpressure: 0xAA held, 16th bit stalls until word_ready rises
    doReset();
    sendBits(8'hAA, 8, 1'b1, 1'b0);
    sendBits(8'h55, 7, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("bp.held", 32'(busM.word_out), 32'hAA);
    checkOutput("bp.count", 32'(busM.bit_count), 32'd7);
    checkOutput("bp.ready", 32'(busM.bit_ready), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("bp.next", 32'(busM.word_out), 32'h55);
    checkOutput("bp.valid", 32'(busM.word_valid), 32'd1);

    // sof after 3 bits discards them
    doReset();
    sendBits(8'h00, 3, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("sof.count", 32'(busM.bit_count), 32'd1);
    sendBits(8'hFF, 7, 1'b0, 1'b1);
    checkOutput("sof.word", 32'(busM.word_out), 32'hFF);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("sof.ignored", 32'(busM.bit_count), 32'd0);

    // Reset mid-word with a pending word
    sendBits(8'h3C, 8, 1'b0, 1'b0);
    sendBits(8'hE0, 5, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("rst.valid", 32'(busM.word_valid), 32'd0);
    checkOutput("rst.word", 32'(busM.word_out), 32'd0);
    checkOutput("rst.count", 32'(busM.bit_count), 32'd0);
    sendBits(8'hC3, 8, 1'b0, 1'b1);
    checkOutput("rst.clean", 32'(busM.word_out), 32'hC3);

    // LSB-first 1,0,1,0,0,0,0,0
    sendBits(8'hA0, 8, 1'b1, 1'b1);
    checkOutput("lsb.word", 32'(busL.word_out), 32'h05);
`ifdef MOD3_TRACK_EN
    checkOutput("lsb.rem", 32'(busL.word_rem), 32'd2);
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 63) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mod3_word_assembler.md
MOD3_WORD_ASSEMBLER -- requirements
Module: mod3_word_assembler

Interface
REQ-001 SHALL have parameter: MSB_FIRST, default 1, 1 = first serial bit lands in word bit 7, 0 = first serial bit lands in word bit 0.
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: bit_in  input  1  serial data bit.
REQ-005 SHALL have port: bit_valid  input  1  bit_in is valid this cycle.
REQ-006 SHALL have port: bit_ready  output  1  block accepts bit_in this cycle.
REQ-007 SHALL have port: sof  input  1  qualified by bit_valid; marks the current bit as the first bit of a new word.
REQ-008 SHALL have port: word_out  output  8  assembled word for the downstream prefix-divisibility stage.
REQ-009 SHALL have port: word_valid  output  1  word_out holds an unconsumed word.
REQ-010 SHALL have port: word_ready  input  1  downstream consumes word_out this cycle.
REQ-011 SHALL have port: bit_count  output  3  bits currently held in the partial word, 0..7.
REQ-012 SHALL have port (MOD3_TRACK_EN only): word_rem  output  2  word_out mod 3.

Function
REQ-013 A bit SHALL be accepted in a cycle where bit_valid and bit_ready are both 1; no other cycle alters the partial word.
REQ-014 The partial-word shift register SHALL place accepted bits per MSB_FIRST; bit_count SHALL increment per accepted bit and wrap 7->0 on the 8th.
REQ-015 On acceptance of the 8th bit, the completed word SHALL load into the output register and word_valid SHALL be 1 on the following cycle (latency 1).
REQ-016 word_valid SHALL clear on a cycle with word_valid && word_ready, unless a new word loads that same cycle, in which case it SHALL stay 1 with the new word.
REQ-017 bit_ready SHALL be 0 only when rst=1 or (bit_count==7 && word_valid && !word_ready); otherwise 1; partial bits 0..6 SHALL always be accepted under output backpressure.
REQ-018 word_out and word_rem SHALL be held stable while word_valid && !word_ready.
REQ-019 An accepted bit with sof=1 SHALL discard any partial word, become bit position 0 of a new word, and set bit_count to 1; a pending output word is unaffected.
REQ-020 sof with bit_valid=0 SHALL be ignored.

Reset
REQ-021 While rst=1: word_out=0, word_valid=0, bit_count=0, word_rem=0, internal remainder=0, partial word=0, bit_ready=0.
REQ-022 Reset mid-word SHALL discard partial bits; reset with word_valid=1 SHALL drop the pending word without handshake.

Configuration
REQ-023 With MOD3_TRACK_EN defined, the block SHALL track a running 2-bit remainder (values 0,1,2 only) updated per accepted bit and present it on word_rem with the word.
REQ-024 MSB_FIRST=1 update SHALL be r' = (2r + b) mod 3; MSB_FIRST=0 SHALL be r' = (r + b*w) mod 3, w=1 for even bit index, 2 for odd.
REQ-025 The remainder SHALL restart from 0 at each word boundary and on sof.
REQ-026 Without MOD3_TRACK_EN, word_rem and all remainder logic SHALL be absent; other behaviour identical.

Structure
REQ-027 Package mod3_pkg SHALL hold WORD_W=8, the 2-bit remainder typedef, and remainder constants REM0/REM1/REM2.
REQ-028 Remainder update SHALL live in one combinational sub-module mod3_step (inputs: remainder, bit, weight; output: next remainder), instantiated only under MOD3_TRACK_EN.

Verification
REQ-029 MSB_FIRST=1, bits 1,0,0,1,0,1,1,0, word_ready=1 -> word_out=0x96, word_valid=1 one cycle after 8th bit, word_rem=0.
REQ-030 MSB_FIRST=1, words 0x07 then 0x05 back-to-back -> word_rem=1 then 2; 0xFF -> word_rem=0.
REQ-031 word_ready=0, stream 16 bits (0xAA, 0x55) -> 0xAA held, bit_ready=0 with bit_count=7; raise word_ready -> 16th bit accepted same cycle, 0x55 valid next cycle, no word lost.
REQ-032 3 bits accepted then sof with bits 1,1,1,1,1,1,1,1 -> word_out=0xFF, partial bits discarded, bit_count=1 after the sof bit.
REQ-033 rst pulse after 5 bits with word_valid=1 -> all outputs 0 next cycle; next 8 bits form a clean word.
REQ-034 MSB_FIRST=0, bits 1,0,1,0,0,0,0,0 -> word_out=0x05, word_rem=2.
